// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared processor encodings for the memory stage
//
// Purpose: pc_src redirect encodings, memory-stage FSM state encodings and
// the wait-counter width shared by mem_stage and its testbench.
package mem_stage_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Counter value loaded on entry to WAIT so that WAIT_STATES stall cycles elapse.
  function automatic logic [CNT_W-1:0] wait_load(input logic [CNT_W-1:0] ws);
    return ws - {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/data_mem.sv
// rtl/data_mem.sv - word-addressed data memory, synchronous write, index read
//
// Purpose: DEPTH x 32-bit storage. Contents are never reset.
// Ports:
//   clk      in   1       rising-edge clock
//   i_we     in   1       write enable, sampled on the rising edge
//   i_addr   in   ADDR_W  word index for both read and write
//   i_wdata  in   32      write data
//   o_rdata  out  32      combinational read of r_mem[i_addr] (pre-write value)
module data_mem #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage with wait-stated data memory and PC redirect
//
// Purpose: executes the EX/MEM slot: loads/stores against data_mem with
// WAIT_STATES extra cycles per access (stalling upstream), resolves
// branch/jump redirects and registers the MEM/WB outputs.
// Optional feature macro: MEM_MISALIGN_TRAP_EN (misaligned memory ops trap
// instead of accessing memory; when undefined, address bits [1:0] are ignored).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid                        EX/MEM slot valid
//   inJump2, inReg2, inMemReg2,
//   inMemW2, inMemR2, inBranch2,
//   inZFlag                         EX/MEM control bits and zero flag
//   inBranchRes, inALURes1,
//   inDR2V, inJAddress2  [31:0]     branch target, ALU result/address, store data, jump target
//   inRegMux1 [4:0]                 destination register
//   stall                           freeze upstream (combinational)
//   pc_src [1:0], pc_target [31:0]  redirect select and address (combinational)
//   flush                           squash younger stages
//   wb_valid, wb_reg_w, wb_mem_reg,
//   wb_rdata, wb_alu_res, wb_rd     MEM/WB register
//   trap                            one-cycle misaligned-access pulse
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        inJump2,
  input  logic        inReg2,
  input  logic        inMemReg2,
  input  logic        inMemW2,
  input  logic        inMemR2,
  input  logic        inBranch2,
  input  logic        inZFlag,
  input  logic [31:0] inBranchRes,
  input  logic [31:0] inALURes1,
  input  logic [31:0] inDR2V,
  input  logic [31:0] inJAddress2,
  input  logic [4:0]  inRegMux1,
  output logic        stall,
  output logic [1:0]  pc_src,
  output logic [31:0] pc_target,
  output logic        flush,
  output logic        wb_valid,
  output logic        wb_reg_w,
  output logic        wb_mem_reg,
  output logic [31:0] wb_rdata,
  output logic [31:0] wb_alu_res,
  output logic [4:0]  wb_rd,
  output logic        trap
);

  localparam int               ADDR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WS     = CNT_W'(WAIT_STATES);

  mem_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_stall_raw;
  logic             w_complete;
  logic             w_mem_op;
  logic             w_misalign;
  logic             w_mem_ok;
  logic             w_we;
  logic [31:0]      w_rdata;
  pc_src_e          w_pc_src;

  logic             r_wb_valid, r_wb_reg_w, r_wb_mem_reg, r_trap;
  logic [31:0]      r_wb_rdata, r_wb_alu_res;
  logic [4:0]       r_wb_rd;

  // Upper address bits wrap modulo DEPTH; the low two bits only matter for the trap.
  logic             w_unused;
  assign w_unused = &{1'b0, inALURes1[31:ADDR_W+2], inALURes1[1:0]};

  assign w_mem_op = in_valid & (inMemR2 | inMemW2);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_misalign = w_mem_op & (inALURes1[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // A misaligned op is treated like a non-memory slot: no stall, no access.
  assign w_mem_ok = w_mem_op & ~w_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall_raw = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_ok && (WS != '0)) begin
          w_stall_raw = 1'b1;
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = wait_load(WS);
        end else begin
          w_complete = 1'b1;
        end
      end
      ST_WAIT: begin
        if (r_cnt != '0) begin
          w_stall_raw = 1'b1;
          w_cnt_nxt   = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Gating with rst_n keeps stall/redirect quiet while reset is asserted,
  // even though the slot inputs may still describe a memory op.
  assign stall = rst_n & w_stall_raw;

  // rst_n gating also prevents a zero-wait store from landing during reset.
  assign w_we = rst_n & w_complete & w_mem_ok & inMemW2;

  data_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_data_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_addr  (inALURes1[ADDR_W+1:2]),
    .i_wdata (inDR2V),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_pc_src  = PC_SEQ;
    pc_target = 32'h0;
    if (rst_n && !w_stall_raw && in_valid) begin
      if (inJump2) begin
        w_pc_src  = PC_JUMP;
        pc_target = inJAddress2;
      end else if (inBranch2 && inZFlag) begin
        w_pc_src  = PC_BRANCH;
        pc_target = inBranchRes;
      end
    end
  end

  assign pc_src = w_pc_src;
  assign flush  = (w_pc_src != PC_SEQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid   <= 1'b0;
      r_wb_reg_w   <= 1'b0;
      r_wb_mem_reg <= 1'b0;
      r_wb_rdata   <= 32'h0;
      r_wb_alu_res <= 32'h0;
      r_wb_rd      <= 5'h0;
      r_trap       <= 1'b0;
    end else begin
      r_trap <= w_misalign;
      if (w_complete) begin
        r_wb_valid   <= in_valid & ~w_misalign;
        r_wb_reg_w   <= inReg2;
        r_wb_mem_reg <= inMemReg2;
        r_wb_alu_res <= inALURes1;
        r_wb_rd      <= inRegMux1;
        // Read data is the pre-write value, so a combined read/write returns old contents.
        if (w_mem_ok && inMemR2) begin
          r_wb_rdata <= w_rdata;
        end
      end else begin
        r_wb_valid <= 1'b0;
      end
    end
  end

  assign wb_valid   = r_wb_valid;
  assign wb_reg_w   = r_wb_reg_w;
  assign wb_mem_reg = r_wb_mem_reg;
  assign wb_rdata   = r_wb_rdata;
  assign wb_alu_res = r_wb_alu_res;
  assign wb_rd      = r_wb_rd;
  assign trap       = r_trap;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard testbench for mem_stage (DEPTH=64, WAIT_STATES=2)
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int DEPTH = 64;
  localparam int WS    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        inJump2 = 1'b0, inReg2 = 1'b0, inMemReg2 = 1'b0, inMemW2 = 1'b0;
  logic        inMemR2 = 1'b0, inBranch2 = 1'b0, inZFlag = 1'b0;
  logic [31:0] inBranchRes = '0, inALURes1 = '0, inDR2V = '0, inJAddress2 = '0;
  logic [4:0]  inRegMux1 = '0;
  logic        stall, flush, wb_valid, wb_reg_w, wb_mem_reg, trap;
  logic [1:0]  pc_src;
  logic [31:0] pc_target, wb_rdata, wb_alu_res;
  logic [4:0]  wb_rd;

  mem_stage #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .inJump2(inJump2), .inReg2(inReg2), .inMemReg2(inMemReg2), .inMemW2(inMemW2),
    .inMemR2(inMemR2), .inBranch2(inBranch2), .inZFlag(inZFlag),
    .inBranchRes(inBranchRes), .inALURes1(inALURes1), .inDR2V(inDR2V),
    .inJAddress2(inJAddress2), .inRegMux1(inRegMux1),
    .stall(stall), .pc_src(pc_src), .pc_target(pc_target), .flush(flush),
    .wb_valid(wb_valid), .wb_reg_w(wb_reg_w), .wb_mem_reg(wb_mem_reg),
    .wb_rdata(wb_rdata), .wb_alu_res(wb_alu_res), .wb_rd(wb_rd), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        mem_reg;
    logic        reg_w;
    logic        is_load;
    logic [31:0] rdata;
  } wb_exp_t;

  wb_exp_t     sb[$];
  logic [31:0] mdl[DEPTH];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    in_valid = 0; inJump2 = 0; inReg2 = 0; inMemReg2 = 0; inMemW2 = 0;
    inMemR2 = 0; inBranch2 = 0; inZFlag = 0; inBranchRes = 0; inALURes1 = 0;
    inDR2V = 0; inJAddress2 = 0; inRegMux1 = 0;
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // Every valid completion pops one expected entry.
  always @(posedge clk) begin
    #2;
    if (wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_wb", wb_valid, 1'b0);
      end else begin
        wb_exp_t e;
        e = sb.pop_front();
        check("wb_rd", 32'(wb_rd), 32'(e.rd));
        check("wb_alu_res", wb_alu_res, e.alu);
        check("wb_mem_reg", 32'(wb_mem_reg), 32'(e.mem_reg));
        check("wb_reg_w", 32'(wb_reg_w), 32'(e.reg_w));
        if (e.is_load) check("wb_rdata", wb_rdata, e.rdata);
      end
    end
  end

  task automatic mem_op(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] rdi, input int exp_stall);
    wb_exp_t e;
    int n;
    @(posedge clk); #1;
    idle_inputs();
    in_valid = 1; inMemR2 = rd; inMemW2 = wr; inALURes1 = addr; inDR2V = data;
    inMemReg2 = rd; inReg2 = rd; inRegMux1 = rdi;
    e.rd = rdi; e.alu = addr; e.mem_reg = rd; e.reg_w = rd; e.is_load = rd;
    e.rdata = mdl[widx(addr)];
    sb.push_back(e);
    if (wr) mdl[widx(addr)] = data;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (stall !== 1'b1) break;
      n++;
      check("pc_src_in_stall", 32'(pc_src), 32'(PC_SEQ));
      if (n >= 2) check("wb_bubble", 32'(wb_valid), 0);
    end
    check("stall_cycles", n, exp_stall);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic ctl_slot(input logic j, input logic b, input logic z,
                          input logic [31:0] ja, input logic [31:0] ba,
                          input logic [1:0] exp_src, input logic [31:0] exp_tgt);
    wb_exp_t e;
    @(posedge clk); #1;
    idle_inputs();
    in_valid = 1; inJump2 = j; inBranch2 = b; inZFlag = z; inJAddress2 = ja;
    inBranchRes = ba; inReg2 = 1; inALURes1 = 32'h1234; inRegMux1 = 5'd9;
    #2;
    check("pc_src", 32'(pc_src), 32'(exp_src));
    check("pc_target", pc_target, exp_tgt);
    check("flush", 32'(flush), 32'(exp_src != 2'b00));
    check("no_stall_ctl", 32'(stall), 0);
    e.rd = 5'd9; e.alu = 32'h1234; e.mem_reg = 0; e.reg_w = 1; e.is_load = 0; e.rdata = 0;
    sb.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    // Hold a memory op on the inputs during reset: nothing may react.
    in_valid = 1; inMemW2 = 1; inJump2 = 1; inJAddress2 = 32'h44;
    #23;
    check("rst_stall", 32'(stall), 0);
    check("rst_pc_src", 32'(pc_src), 0);
    check("rst_flush", 32'(flush), 0);
    check("rst_wb_valid", 32'(wb_valid), 0);
    check("rst_wb_rdata", wb_rdata, 0);
    check("rst_trap", 32'(trap), 0);
    idle_inputs();
    @(negedge clk); rst_n = 1;

    // Initialise every word used by later loads.
    mem_op(0, 1, 32'h0000_0000, 32'h0, 5'd0, WS);
    mem_op(0, 1, 32'h0000_0020, 32'h1111_2222, 5'd0, WS);

    // Store then load back.
    mem_op(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0, WS);
    mem_op(1, 0, 32'h0000_0010, 32'h0, 5'd5, WS);

    // Combined read+write returns the pre-write word.
    mem_op(1, 1, 32'h0000_0020, 32'h5555_6666, 5'd7, WS);
    mem_op(1, 0, 32'h0000_0020, 32'h0, 5'd8, WS);
    mem_op(0, 1, 32'h0000_0020, 32'h1111_2222, 5'd0, WS);

    // Redirects: jump beats branch, then branch alone, then not-taken, then invalid slot.
    ctl_slot(1, 1, 1, 32'h400, 32'h80, PC_JUMP, 32'h400);
    ctl_slot(0, 1, 1, 32'h400, 32'h80, PC_BRANCH, 32'h80);
    ctl_slot(0, 1, 0, 32'h400, 32'h80, PC_SEQ, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    inJump2 = 1; inJAddress2 = 32'h400;
    #2;
    check("invalid_no_jump", 32'(pc_src), 0);
    check("invalid_no_flush", 32'(flush), 0);
    idle_inputs();

    // Reset in the middle of a store to 0x20: access abandoned.
    @(posedge clk); #1;
    in_valid = 1; inMemW2 = 1; inALURes1 = 32'h20; inDR2V = 32'h3333_4444;
    @(negedge clk);
    check("abort_stall_before", 32'(stall), 1);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("abort_stall", 32'(stall), 0);
    check("abort_wb_valid", 32'(wb_valid), 0);
    check("abort_wb_rd", 32'(wb_rd), 0);
    check("abort_wb_alu", wb_alu_res, 0);
    idle_inputs();
    @(negedge clk); rst_n = 1;
    mem_op(1, 0, 32'h0000_0020, 32'h0, 5'd3, WS);

`ifdef MEM_MISALIGN_TRAP_EN
    @(posedge clk); #1;
    in_valid = 1; inMemW2 = 1; inALURes1 = 32'h13; inDR2V = 32'h0BAD_0BAD; inReg2 = 1;
    #1;
    check("mis_no_stall", 32'(stall), 0);
    @(posedge clk); #1;
    check("mis_trap", 32'(trap), 1);
    check("mis_wb_valid", 32'(wb_valid), 0);
    idle_inputs();
    @(posedge clk); #1;
    check("mis_trap_pulse", 32'(trap), 0);
    mem_op(1, 0, 32'h0000_0010, 32'h0, 5'd4, WS);
`else
    check("trap_tied", 32'(trap), 0);
`endif

    // Address wrap: 0x100 aliases word 0.
    mem_op(0, 1, 32'h0000_0100, 32'hCAFE_F00D, 5'd0, WS);
    mem_op(1, 0, 32'h0000_0000, 32'h0, 5'd6, WS);

    repeat (3) @(posedge clk);
    #3;
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameters: DEPTH, default 64, data-memory words; WAIT_STATES, default 2, extra cycles per memory access (0..15).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: in_valid  in  1  EX/MEM slot valid; inJump2, inReg2, inMemReg2, inMemW2, inMemR2, inBranch2, inZFlag  in  1 each  EX/MEM control and zero flag.
REQ-004 SHALL have ports: inBranchRes, inALURes1, inDR2V, inJAddress2  in  32 each  branch target, ALU result/address, store data, jump target; inRegMux1  in  5  destination register.
REQ-005 SHALL have ports: stall  out  1  freeze upstream; pc_src  out  2  00 sequential, 01 branch, 10 jump; pc_target  out  32  redirect address; flush  out  1  squash younger stages.
REQ-006 SHALL have ports: wb_valid, wb_reg_w, wb_mem_reg  out  1 each; wb_rdata, wb_alu_res  out  32 each; wb_rd  out  5  (MEM/WB register); trap  out  1  misaligned-access pulse.

Function
REQ-007 SHALL treat a slot as a memory op when in_valid & (inMemR2 | inMemW2).
REQ-008 SHALL implement FSM IDLE/WAIT with a 4-bit wait counter cnt.
REQ-009 IDLE, memory op, WAIT_STATES>0: stall=1 combinationally, next state WAIT, cnt loaded with WAIT_STATES-1.
REQ-010 WAIT: stall=(cnt!=0); cnt decrements each edge; at cnt==0 stall=0 and the access completes on that edge, next state IDLE.
REQ-011 Memory op with WAIT_STATES=0, or non-memory slot: no stall, completes on the presenting edge.
REQ-012 Upstream SHALL hold all in* inputs stable while stall=1; the block does not re-sample them mid-access.
REQ-013 Word index SHALL be inALURes1[log2(DEPTH)+1:2]; higher bits ignored (address wraps modulo DEPTH).
REQ-014 Store SHALL write inDR2V at the completing edge only; load SHALL capture mem[index] into wb_rdata at the completing edge.
REQ-015 inMemR2 & inMemW2 together: write performed, wb_rdata receives pre-write data.
REQ-016 On completion SHALL register wb_valid=in_valid, wb_reg_w=inReg2, wb_mem_reg=inMemReg2, wb_alu_res=inALURes1, wb_rd=inRegMux1; wb_rdata updates only for loads.
REQ-017 While stall=1 SHALL register wb_valid=0 (bubble into WB).
REQ-018 pc_src (combinational, only when stall=0 and in_valid): 10 if inJump2; else 01 if inBranch2 & inZFlag; else 00. Jump has priority.
REQ-019 pc_target SHALL be inJAddress2 for 10, inBranchRes for 01, 0 otherwise; flush=(pc_src!=00).
REQ-020 in_valid=0 SHALL suppress memory writes, stall, redirect and trap.

Reset
REQ-021 rst_n low SHALL force immediately: state IDLE, cnt 0, all wb_* 0, trap 0; stall, pc_src and flush then evaluate to 0.
REQ-022 Reset mid-access SHALL abandon the access with no memory write; memory contents are not reset.

Configuration
REQ-023 With MEM_MISALIGN_TRAP_EN defined: memory op with inALURes1[1:0]!=00 SHALL not stall or write, SHALL register wb_valid=0, and SHALL pulse trap high for exactly one cycle on the next edge.
REQ-024 Without MEM_MISALIGN_TRAP_EN: address bits [1:0] ignored, trap tied 0, port list unchanged.

Structure
REQ-025 pc_src encodings (PC_SEQ, PC_BRANCH, PC_JUMP) and FSM state encodings SHALL live in the shared processor package.
REQ-026 The data memory array SHALL be a sub-module data_mem (synchronous write, index-addressed read) instantiated once.

Verification
REQ-027 WAIT_STATES=2; store inALURes1=0x10, inDR2V=0xDEADBEEF -> stall high 2 cycles, write at 3rd edge, wb_valid=1 there.
REQ-028 Then load from 0x10, inMemReg2=1, inRegMux1=5 -> after 2 stall cycles wb_rdata=0xDEADBEEF, wb_rd=5, wb_valid=1; wb_valid=0 during stall.
REQ-029 inBranch2=1, inZFlag=1, inJump2=1, inJAddress2=0x400, inBranchRes=0x80 -> pc_src=10, pc_target=0x400, flush=1; inJump2=0 -> pc_src=01, pc_target=0x80.
REQ-030 rst_n low during WAIT of store to 0x20 -> state IDLE, stall 0, wb_* 0; subsequent load of 0x20 returns prior contents.
REQ-031 MEM_MISALIGN_TRAP_EN, store to 0x13 -> no stall, trap pulses one cycle, memory word 4 unchanged, wb_valid=0.
REQ-032 DEPTH=64, store to 0x100 then load 0x000 -> same word (wrap), data matches.
